// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5,
        StErr   = 3'd6
    } state_e;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; flags the byte that completes a word.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_xfer_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_xfer_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // The completing byte is merged combinationally so the word is ready on its own edge.
    assign word_ready_o = byte_xfer_i && (cnt_q == 2'(WORD_BYTES - 1));
    assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed word image over a byte link, writes it into
// instruction memory and holds the CPU core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_rst_n,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_loaded
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_new;
    logic [LEN_W-1:0]  words_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              cpu_rst_n_q;
    logic              xfer;
    logic              start_ok;
    logic              word_ready;
    logic [31:0]       word;

    assign xfer     = byte_valid && byte_ready;
    assign start_ok = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign len_new  = LEN_W'({len_hi_q, byte_in});

    imem_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .byte_xfer_i  (xfer && (state_q == StData)),
        .byte_i       (byte_in),
        .word_ready_o (word_ready),
        .word_o       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLenHi;
            end
            StLenHi: begin
                if (xfer) state_d = StLenLo;
            end
            StLenLo: begin
                if (xfer) begin
                    if (len_new == '0)              state_d = StDone;
                    else if (32'(len_new) > Depth)  state_d = StErr;
                    else                            state_d = StData;
                end
            end
            StData: begin
                if (word_ready) state_d = StWrite;
            end
            StWrite: begin
                if ((words_q + LEN_W'(1)) == len_q) state_d = StDone;
                else                                state_d = StData;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            StLenHi, StLenLo, StData: byte_ready = 1'b1;
            StWrite:                  imem_we    = 1'b1;
            StDone:                   done       = 1'b1;
            StErr:                    error      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi_q    <= '0;
            len_q       <= '0;
            words_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            if (state_q == StLenHi && xfer) len_hi_q <= byte_in;
            if (state_q == StLenLo && xfer) len_q <= len_new;
            if (start_ok) begin
                words_q <= '0;
            end else if (state_q == StWrite) begin
                words_q <= words_q + LEN_W'(1);
            end
            // Address and data are captured on entry to WRITE and held afterwards.
            if (word_ready) begin
                addr_q  <= words_q[ADDR_W-1:0];
                wdata_q <= word;
            end
            cpu_rst_n_q <= (state_d == StIdle) || (state_d == StDone);
        end
    end

    assign imem_addr    = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign imem_wdata   = wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign words_loaded = words_q;

endmodule
